// File: rtl/rbot_moves_pkg.sv
// Shared definitions for the scan-move path: move codes, dispatcher states, batch size.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package rbot_moves_pkg;

  // Move slots per batch; each slot is one 4-bit move code.
  localparam int SLOTS = 50;

  typedef logic [3:0] move_t;

  localparam move_t MOVE_EMPTY = 4'd0;
  localparam move_t R  = 4'd2;
  localparam move_t Ri = 4'd3;
  localparam move_t U  = 4'd4;
  localparam move_t Ui = 4'd5;
  localparam move_t F  = 4'd6;
  localparam move_t Fi = 4'd7;
  localparam move_t L  = 4'd8;
  localparam move_t Li = 4'd9;
  localparam move_t B  = 4'd10;
  localparam move_t Bi = 4'd11;
  localparam move_t D  = 4'd12;
  localparam move_t Di = 4'd13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ISSUE,
    ST_WAIT,
    ST_SETTLE,
    ST_NEXT,
    ST_DONE
  } dispatch_state_t;

  // Codes R..Di form one contiguous range; 0 is empty, 1/14/15 are malformed.
  function automatic logic is_valid_move(input move_t code);
    return (code >= R) && (code <= Di);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Down-counter that fires once, `count` cycles after a load strobe.
// Latency: `expired` is high in the count-th cycle after load (count 0 behaves as 1).
// Backpressure: none; a new load restarts the interval.
//
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   load         : start a new interval
//   count        : interval length in cycles, sampled on load
//   expired      : one-cycle pulse at the end of the interval
module settle_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] count,
  output logic        expired
);

  logic [15:0] remaining;
  logic        running;

  // Fires while the last cycle of the interval is being spent.
  assign expired = running && (remaining <= 16'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      remaining <= '0;
      running   <= 1'b0;
    end else if (load) begin
      remaining <= count;
      running   <= 1'b1;
    end else if (expired) begin
      remaining <= '0;
      running   <= 1'b0;
    end else if (running) begin
      remaining <= remaining - 16'd1;
    end
  end

endmodule

// File: rtl/move_dispatcher.sv
// Unpacks a batch of move codes (highest slot first) and issues each valid one to the motor driver.
// Latency: first move valid 1 cycle after accept (+1 per skipped slot); >=2 cycles move_done to next move.
// Backpressure: move/move_valid held until move_ready; next move waits for move_done (+ settle interval).
//
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   moves, new_moves    : packed batch (slot k at [4k+3:4k]) and its one-cycle strobe
//   busy                : batch in progress
//   move, move_valid    : move code to the driver, held until move_ready
//   move_ready          : driver accepts the presented move
//   move_done           : driver finished the accepted move
//   batch_done          : one-cycle pulse when the batch is complete
//   move_count          : moves issued in the current/last batch (saturating)
//   overrun, bad_code   : sticky error flags, cleared only by reset
//
// Build option: define DISPATCH_SETTLE_EN to wait SETTLE_CYCLES after every move_done.
module move_dispatcher #(
  parameter int          SLOTS         = rbot_moves_pkg::SLOTS,
  parameter logic [15:0] SETTLE_CYCLES = 16'd50000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [4*SLOTS-1:0] moves,
  input  logic               new_moves,
  output logic               busy,
  output logic [3:0]         move,
  output logic               move_valid,
  input  logic               move_ready,
  input  logic               move_done,
  output logic               batch_done,
  output logic [5:0]         move_count,
  output logic               overrun,
  output logic               bad_code
);

  import rbot_moves_pkg::*;

  dispatch_state_t state, state_nxt;

  logic [4*SLOTS-1:0] batch;
  logic [5:0]         idx;
  move_t              cur_code;
  logic               code_ok;
  logic               busy_nxt, valid_nxt, done_nxt;
  logic               settle_expired;

  assign cur_code = batch[idx*4 +: 4];
  assign code_ok  = is_valid_move(cur_code);

`ifdef DISPATCH_SETTLE_EN
  logic settle_load;

  // The interval starts on the same edge the dispatcher leaves WAIT.
  assign settle_load = (state == ST_WAIT) && move_done;

  settle_timer u_settle (
    .clock   (clock),
    .reset   (reset),
    .load    (settle_load),
    .count   (SETTLE_CYCLES),
    .expired (settle_expired)
  );
`else
  assign settle_expired = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (new_moves) state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (code_ok)          state_nxt = ST_ISSUE;
        else if (idx == 6'd0) state_nxt = ST_DONE;
      end
      ST_ISSUE: if (move_ready) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (move_done) begin
`ifdef DISPATCH_SETTLE_EN
          state_nxt = ST_SETTLE;
`else
          state_nxt = ST_NEXT;
`endif
        end
      end
      ST_SETTLE: if (settle_expired) state_nxt = ST_NEXT;
      ST_NEXT:  state_nxt = (idx == 6'd0) ? ST_DONE : ST_SCAN;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered handshake/status outputs,
  // decoded from the state being entered so the outputs come straight from flops.
  always_comb begin
    busy_nxt  = (state_nxt != ST_IDLE);
    valid_nxt = (state_nxt == ST_ISSUE);
    done_nxt  = (state == ST_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      batch      <= '0;
      idx        <= '0;
      move       <= MOVE_EMPTY;
      move_valid <= 1'b0;
      busy       <= 1'b0;
      batch_done <= 1'b0;
      move_count <= '0;
      overrun    <= 1'b0;
      bad_code   <= 1'b0;
    end else begin
      busy       <= busy_nxt;
      move_valid <= valid_nxt;
      batch_done <= done_nxt;

      // A strobe during a batch is dropped; only the flag records it.
      if (new_moves && (state != ST_IDLE)) overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (new_moves) begin
            batch      <= moves;
            idx        <= 6'(SLOTS - 1);
            move_count <= '0;
          end
        end
        ST_SCAN: begin
          if (code_ok) begin
            move <= cur_code;
            if (move_count != 6'(SLOTS)) move_count <= move_count + 6'd1;
          end else begin
            if (cur_code != MOVE_EMPTY) bad_code <= 1'b1;
            if (idx != 6'd0) idx <= idx - 6'd1;
          end
        end
        // Index of an issued slot is only advanced once its move has completed.
        ST_NEXT: begin
          if (idx != 6'd0) idx <= idx - 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/move_dispatcher.md
# move_dispatcher

Sequencer between the scan-move generator and the motor driver. It accepts one packed batch of 50 four-bit move codes per `new_moves` pulse and unpacks it in execution order. Each valid move is issued to the motor driver over a valid/ready + done handshake, with an optional mechanical settle interval after every move. It reports batch completion back to the scan controller so the controller can advance its observation counter.

## Interface
Parameters:
- `SLOTS`, default 50: move slots per batch; batch width is `4*SLOTS`.
- `SETTLE_CYCLES`, default 16'd50000: clock cycles waited after each `move_done`. Only used with `DISPATCH_SETTLE_EN`.

Ports:
- `clock`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `moves`, input, 200: packed batch. Slot k occupies bits [4k+3:4k]; code 0 means an empty slot.
- `new_moves`, input, 1: one-cycle strobe; `moves` is valid in the same cycle.
- `busy`, output, 1: high from batch accept until `batch_done`.
- `move`, output, 4: move code presented to the motor driver.
- `move_valid`, output, 1: `move` is valid and held until accepted.
- `move_ready`, input, 1: motor driver accepts `move` when high with `move_valid`.
- `move_done`, input, 1: one-cycle strobe, motor finished the accepted move.
- `batch_done`, output, 1: one-cycle strobe, the last move of the batch has completed.
- `move_count`, output, 6: number of moves issued in the current or last batch.
- `overrun`, output, 1: sticky; a `new_moves` strobe arrived while `busy`.
- `bad_code`, output, 1: sticky; a slot held code 1, 14 or 15.

## Operation
- Move codes: R=2, Ri=3, U=4, Ui=5, F=6, Fi=7, L=8, Li=9, B=10, Bi=11, D=12, Di=13. Codes 2..13 are valid.
- Execution order is highest slot first, i.e. slot 49 down to slot 0. Empty slots are skipped, including interior ones.
- State IDLE:
  - On `new_moves`, latch `moves`, set slot index to `SLOTS-1`, clear `move_count`, go to SCAN.
- State SCAN: one slot examined per cycle.
  - Valid code: drive `move` with the code, raise `move_valid`, increment `move_count`, go to ISSUE.
  - Code 0: skip the slot.
  - Codes 1, 14, 15: set `bad_code` and skip the slot.
  - After slot 0 has been examined and skipped, go to DONE.
- State ISSUE: hold `move` and `move_valid` until `move_ready` is high. On the accepting edge, drop `move_valid` and go to WAIT.
- State WAIT: on `move_done`, go to SETTLE if the macro is defined, else to NEXT.
- State SETTLE: count `SETTLE_CYCLES` cycles, then go to NEXT.
- State NEXT: if the slot index is 0, go to DONE; otherwise decrement the index and go to SCAN.
- State DONE: pulse `batch_done` for one cycle, drop `busy`, return to IDLE.
- A `new_moves` strobe in any state other than IDLE sets `overrun`. The strobe is dropped and the batch in flight is unaffected.
- A `move_done` outside WAIT is ignored.
- `move_count` saturates at 50 and never wraps.
- `overrun` and `bad_code` are cleared only by `reset`.

## Timing
- Reset values: state IDLE; `busy`, `move_valid`, `batch_done`, `overrun`, `bad_code` all 0; `move` 0; `move_count` 0.
- Reset asserted mid-batch returns to IDLE immediately. `move_valid` drops asynchronously and the batch is discarded.
- Latency from `new_moves` at edge N:
  - `busy` is high after edge N.
  - If slot 49 is valid, `move_valid` is high after edge N+1.
  - Each skipped slot adds one cycle.
- Batch of all zeros: `batch_done` is high after edge N+51 and `move_valid` never rises.
- Between moves, with no settle, `move_done` to the next `move_valid` takes at least 2 cycles (NEXT, then SCAN), plus one cycle per skipped slot.
- `move_done` is never expected in the same cycle as acceptance. If it arrives then, it is ignored.
- `move_valid` and `move` are registered outputs and never change while waiting for `move_ready`.

## Configuration
- `DISPATCH_SETTLE_EN`:
  - Defined: the SETTLE state exists and waits `SETTLE_CYCLES` after every `move_done`, including the last move of a batch.
  - Undefined: the SETTLE state and its counter are removed, and WAIT goes straight to NEXT.

## Structure
- Package `rbot_moves_pkg` holds:
  - move-code constants `R`..`Di` and `MOVE_EMPTY`=0;
  - function `is_valid_move`;
  - the dispatcher state enum;
  - `SLOTS`.
- Sub-module `settle_timer`, instantiated only under the macro. It takes a load strobe and a cycle count, and produces a `expired` pulse.

## Test plan
- Batch with R,Li,U,Ui in bits [15:0] and the rest zero, `move_ready` tied high, done 3 cycles after accept:
  - moves issued in order 2, 9, 4, 5;
  - `move_count`=4;
  - exactly one `batch_done`.
- All-zero batch: `batch_done` after edge N+51; `move_valid` stays 0; `move_count`=0.
- `new_moves` pulsed while in WAIT:
  - `overrun`=1;
  - the current batch completes with the original moves;
  - no second `batch_done`.
- Batch with F, 4'hF, Fi in bits [11:0]:
  - issued sequence is 6, 7;
  - `bad_code`=1;
  - `move_count`=2.
- `move_ready` low for 10 cycles with `move_valid` high: `move` stays stable and exactly one acceptance occurs.
- Reset asserted during WAIT: all outputs return to reset values, then a fresh batch runs normally. With `DISPATCH_SETTLE_EN` and `SETTLE_CYCLES`=4, the next `move_valid` comes 4 cycles later than without the macro.
